// File: rtl/instr_cache_pkg.sv
// Shared FSM type and address-field helpers for the direct-mapped instruction cache.
package instr_cache_pkg;

  typedef enum logic [1:0] {RUN, REFILL_REQ, REFILL_DATA, RESPOND} state_t;

  localparam int BYTE_W = 2;

  function automatic int word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_width, input int num_lines, input int line_words);
    return addr_width - BYTE_W - $clog2(num_lines) - $clog2(line_words);
  endfunction

  // Generic bit-field extract; callers cast the result down to the field width.
  function automatic logic [63:0] field(input logic [63:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_word(input logic [63:0] addr, input int ww);
    return field(addr, BYTE_W, ww);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int ww, input int iw);
    return field(addr, BYTE_W + ww, iw);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int ww, input int iw,
                                           input int tw);
    return field(addr, BYTE_W + ww + iw, tw);
  endfunction

endpackage

// File: rtl/instr_cache_data_ram.sv
// Line data store: one synchronous write port for refill beats, one combinational read port.
module instr_cache_data_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: registered-address lookup, blocking
// multi-beat line refill, kill/flush handling from the fetch stage.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int NUM_LINES   = 8,
  parameter int LINE_WORDS  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_req_valid,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  output logic                   o_req_ready,
  output logic                   o_rsp_valid,
  output logic [INSTR_WIDTH-1:0] o_rsp_instr,
  input  logic                   i_kill,
  input  logic                   i_flush,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data
);

  localparam int WORD_W = word_w(LINE_WORDS);
  localparam int IDX_W  = index_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_WIDTH, NUM_LINES, LINE_WORDS);
  localparam int OFF_W  = BYTE_W + WORD_W;

  state_t                 state, state_nx;
  logic                   lk_pend, kill_q, flush_q;
  logic [ADDR_WIDTH-1:0]  lk_addr;
  logic [NUM_LINES-1:0]   line_vld;
  logic [TAG_W-1:0]       tag_mem [NUM_LINES];
  logic [WORD_W-1:0]      beat;

  logic [IDX_W-1:0]       lk_idx;
  logic [WORD_W-1:0]      lk_word;
  logic [TAG_W-1:0]       lk_tag;
  logic                   hit, lookup, miss, accept;
  logic                   in_refill, beat_we, last_beat, install, flush_now;
  logic [INSTR_WIDTH-1:0] rd_data;

  // The lookup address is also the miss address: it is frozen while the refill runs.
  assign lk_word = WORD_W'(addr_word(64'(lk_addr), WORD_W));
  assign lk_idx  = IDX_W'(addr_index(64'(lk_addr), WORD_W, IDX_W));
  assign lk_tag  = TAG_W'(addr_tag(64'(lk_addr), WORD_W, IDX_W, TAG_W));

  assign hit       = line_vld[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lookup    = (state == RUN) && lk_pend;
  assign miss      = lookup && !hit;
  assign accept    = i_req_valid && o_req_ready;
  assign in_refill = (state == REFILL_REQ) || (state == REFILL_DATA);
  assign beat_we   = (state == REFILL_DATA) && i_mem_rsp_valid;
  assign last_beat = (beat == WORD_W'(LINE_WORDS - 1));
  assign install   = beat_we && last_beat;
  // A flush seen during refill waits until the line is installed, then lands on entry to RUN.
  assign flush_now = ((state == RUN) && i_flush) || ((state == RESPOND) && (flush_q || i_flush));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= RUN;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:         if (miss && !i_kill) state_nx = REFILL_REQ;
      REFILL_REQ:  if (i_mem_req_ready) state_nx = REFILL_DATA;
      REFILL_DATA: if (install) state_nx = RESPOND;
      RESPOND:     state_nx = RUN;
      default:     state_nx = RUN;
    endcase
  end

  // Ready also rises in RESPOND so the next fetch is accepted alongside the refill response.
  always_comb begin
    o_req_ready     = 1'b0;
    o_rsp_valid     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_addr      = '0;
    case (state)
      RUN: begin
        o_req_ready = !miss;
        o_rsp_valid = lookup && hit && !i_kill;
      end
      REFILL_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_addr      = {lk_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      end
      RESPOND: begin
        o_req_ready = 1'b1;
        o_rsp_valid = !kill_q && !i_kill;
      end
      default: ;
    endcase
  end

  assign o_rsp_instr = o_rsp_valid ? rd_data : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lk_pend  <= 1'b0;
      lk_addr  <= '0;
      kill_q   <= 1'b0;
      flush_q  <= 1'b0;
      beat     <= '0;
      line_vld <= '0;
    end else begin
      lk_pend <= accept;
      if (accept) lk_addr <= i_req_addr;
      kill_q  <= in_refill && (kill_q || i_kill);
      flush_q <= in_refill && (flush_q || i_flush);
      if (beat_we) beat <= beat + WORD_W'(1);
      if (flush_now)    line_vld         <= '0;
      else if (install) line_vld[lk_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (install) tag_mem[lk_idx] <= lk_tag;
  end

  instr_cache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .WIDTH (INSTR_WIDTH)
  ) u_data (
    .i_clk   (i_clk),
    .i_we    (beat_we),
    .i_waddr ({lk_idx, beat}),
    .i_wdata (i_mem_rsp_data),
    .i_raddr ({lk_idx, lk_word}),
    .o_rdata (rd_data)
  );

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench: a line-level cache model predicts responses, refill addresses and timing.
module tb_instr_cache;

  localparam int AW = 32, IW = 32, NL = 8, LW = 4;
  localparam int LINE_B = 4 * LW;

  typedef struct { logic [IW-1:0] data; int due; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic kill = 1'b0, flush = 1'b0;
  logic mem_req_ready, mem_rsp_valid;
  logic [IW-1:0] mem_rsp_data;
  logic req_ready, rsp_valid, mem_req_valid;
  logic [IW-1:0] rsp_instr;
  logic [AW-1:0] mem_addr;

  instr_cache #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_instr(rsp_instr),
    .i_kill(kill), .i_flush(flush),
    .o_mem_req_valid(mem_req_valid), .o_mem_addr(mem_addr), .i_mem_req_ready(mem_req_ready),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int stall_cfg = 0, gap_cfg = 0;
  bit junk_en = 1'b0;
  exp_t rsp_q[$];
  logic [AW-1:0] mem_q[$];
  bit mv[NL];
  int unsigned mt[NL];
  bit busy = 1'b0, seen = 1'b0;
  int m_beat = 0, gap_left = 0, stall_left = 0;
  logic [AW-1:0] base = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] memfn(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Reference model: direct-mapped line table updated at request acceptance.
  task automatic model_accept(input logic [AW-1:0] a, input int kmode, input int acc);
    int unsigned ua, idx, tg;
    bit hit;
    ua  = a;
    idx = (ua / LINE_B) % NL;
    tg  = ua / (LINE_B * NL);
    hit = mv[idx] && (mt[idx] == tg);
    if (kmode == 1) return;
    if (!hit) begin
      mem_q.push_back(a & ~(AW'(LINE_B - 1)));
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    if (kmode == 0)
      rsp_q.push_back('{memfn(a & ~(AW'(3))),
                        hit ? acc + 1 : acc + 4 + stall_cfg + (LW - 1) * (gap_cfg + 1)});
  endtask

  // Memory model: optional request stall, then beats with a fixed gap; junk beats when idle.
  always @(negedge clk) begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (!rst_n) begin
      busy = 1'b0; seen = 1'b0; m_beat = 0;
    end else if (busy) begin
      if (gap_left > 0) gap_left--;
      else begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = memfn(base + AW'(4 * m_beat));
        m_beat++;
        gap_left = gap_cfg;
        if (m_beat == LW) busy = 1'b0;
      end
    end else if (mem_req_valid) begin
      if (!seen) begin
        seen = 1'b1;
        stall_left = stall_cfg;
        base = mem_addr;
        if (mem_q.size() == 0) fail("unexpected mem request");
        else check("mem_addr", 64'(mem_addr), 64'(mem_q.pop_front()));
      end else check("mem_addr hold", 64'(mem_addr), 64'(base));
      if (stall_left > 0) stall_left--;
      else begin
        mem_req_ready = 1'b1; seen = 1'b0; busy = 1'b1; m_beat = 0; gap_left = 0;
      end
    end else if (junk_en && $urandom_range(3) == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
    end
  end

  // Monitor samples after the driver has settled kill for this cycle.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && rsp_valid) begin
      if (rsp_q.size() == 0) fail("unexpected rsp");
      else begin
        exp_t e;
        e = rsp_q.pop_front();
        check("rsp_instr", 64'(rsp_instr), 64'(e.data));
        check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      kill = 1'b0;
      flush = 1'b0;
    end
  endtask

  // kmode: 0 normal, 1 kill in the lookup cycle, 2 response will be killed during refill.
  task automatic fetch(input logic [AW-1:0] a, input int kmode);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      kill = 1'b0; flush = 1'b0;
      t++;
    end
    if (!req_ready) begin
      fail("req_ready timeout");
      req_valid = 1'b0;
      return;
    end
    model_accept(a, kmode, cyc);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    kill  = (kmode == 1);
  endtask

  task automatic wait_refill();
    int t;
    t = 0;
    while (!busy && t < 200) begin @(negedge clk); t++; end
    if (!busy) fail("refill start timeout");
  endtask

  task automatic pulse(input bit is_kill);
    if (is_kill) kill = 1'b1;
    else begin
      flush = 1'b1;
      foreach (mv[i]) mv[i] = 1'b0;
    end
    idle(1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0 || busy || mem_req_valid || !req_ready)
           && t < 1000) begin
      @(negedge clk);
      kill = 1'b0; flush = 1'b0;
      t++;
    end
    if (t >= 1000) begin
      fail("drain timeout");
      rsp_q.delete();
      mem_q.delete();
    end
    idle(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mv[i]) mv[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_instr", 64'(rsp_instr), 64'd0);
    check("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("reset mem_addr", 64'(mem_addr), 64'd0);
    #1 rst_n = 1'b1;
    #1 check("ready after reset", 64'(req_ready), 64'd1);
    @(negedge clk);

    // cold miss then three hits from the same line
    fetch(32'h0, 0); fetch(32'h4, 0); fetch(32'h8, 0); fetch(32'hC, 0);
    drain();
    // conflict on index 0
    fetch(32'h80, 0); drain();
    fetch(32'h0, 0);  drain();
    // memory stalls
    stall_cfg = 3; gap_cfg = 2;
    fetch(32'h100, 0); drain();
    stall_cfg = 0; gap_cfg = 0;
    // kill during refill: line still installed
    fetch(32'h40, 2); wait_refill(); pulse(1'b1); drain();
    fetch(32'h44, 0); drain();
    // kill in lookup cycle, new request in the same cycle
    fetch(32'h44, 1); fetch(32'h48, 0); drain();
    fetch(32'h200, 1); fetch(32'h200, 0); drain();
    // flush during refill
    fetch(32'h300, 0); wait_refill(); pulse(1'b0); drain();
    fetch(32'h300, 0); drain();
    // flush while idle
    pulse(1'b0); fetch(32'h0, 0); drain();

    // randomized bursts
    junk_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      stall_cfg = $urandom_range(2);
      gap_cfg   = $urandom_range(2);
      for (int i = 0; i < 25; i++) begin
        logic [AW-1:0] a;
        int km;
        a  = AW'($urandom_range(511));
        km = ($urandom_range(9) == 0) ? 1 : 0;
        fetch(a, km);
        if ($urandom_range(3) == 0) idle(int'($urandom_range(3, 1)));
      end
      drain();
    end

    // reset in the middle of a refill
    stall_cfg = 0; gap_cfg = 1;
    pulse(1'b0);
    fetch(32'h180, 0);
    begin
      int t;
      t = 0;
      while (!(busy && m_beat == 2) && t < 200) begin @(posedge clk); t++; end
      if (t >= 200) fail("beat 2 timeout");
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("mid-reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid-reset rsp_instr", 64'(rsp_instr), 64'd0);
    rsp_q.delete();
    mem_q.delete();
    foreach (mv[i]) mv[i] = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("ready after mid reset", 64'(req_ready), 64'd1);
    @(negedge clk);
    gap_cfg = 0;
    fetch(32'h0, 0); fetch(32'h4, 0); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
